// File: rtl/agnus_blitter_pkg.sv
// Shared definitions for the Agnus area-mode blitter channel sequencer.
package agnus_blitter_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SLOT    = 2'd1,
    ST_FLUSH_D = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Pointer/modulo select codes seen by the address generator
  localparam logic [1:0] CHA = 2'b10;
  localparam logic [1:0] CHB = 2'b01;
  localparam logic [1:0] CHC = 2'b00;
  localparam logic [1:0] CHD = 2'b11;

  // One-hot channel strobes, ordered {A,B,C,D}
  localparam logic [3:0] STB_A = 4'b1000;
  localparam logic [3:0] STB_B = 4'b0100;
  localparam logic [3:0] STB_C = 4'b0010;
  localparam logic [3:0] STB_D = 4'b0001;

  // Consecutive granted slots before the sequencer gives one cycle back to the bus
  localparam int unsigned YIELD_AFTER = 3;

  // Map a channel select code to its one-hot strobe
  function automatic logic [3:0] chan_onehot(input logic [1:0] ch);
    case (ch)
      CHA:     return STB_A;
      CHB:     return STB_B;
      CHC:     return STB_C;
      default: return STB_D;
    endcase
  endfunction

endpackage

// File: rtl/agnus_blitter_sizecnt.sv
// Blit width/height counters: load at start, step once per finished word.
// A zero width or height loads as the full power-of-two size.
module agnus_blitter_sizecnt #(
  parameter int unsigned WBITS = 6,
  parameter int unsigned HBITS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic             step,
  input  logic [WBITS-1:0] width,
  input  logic [HBITS-1:0] height,
  output logic             lastcol,
  output logic             lastword
);

  localparam int unsigned CW = WBITS + 1;
  localparam int unsigned RW = HBITS + 1;

  logic [CW-1:0] col;
  logic [CW-1:0] col_reload;
  logic [RW-1:0] row;
  logic [CW-1:0] width_ld;
  logic [RW-1:0] height_ld;

  // Zero-size expansion of the programmed dimensions
  always_comb begin
    width_ld  = (width == '0)  ? (CW'(1) << WBITS) : CW'(width);
    height_ld = (height == '0) ? (RW'(1) << HBITS) : RW'(height);
  end

  // Column counts down within a row and reloads at row end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col        <= '0;
      col_reload <= '0;
      row        <= '0;
    end else if (en) begin
      if (load) begin
        col        <= width_ld;
        col_reload <= width_ld;
        row        <= height_ld;
      end else if (step) begin
        if (col == CW'(1)) begin
          col <= col_reload;
          row <= row - RW'(1);
        end else begin
          col <= col - CW'(1);
        end
      end
    end
  end

  // Flags describing the word currently being accessed
  always_comb begin
    lastcol  = (col == CW'(1));
    lastword = lastcol && (row == RW'(1));
  end

endmodule

// File: rtl/agnus_blitter_sequencer.sv
// Area-mode blitter channel sequencer: walks the blit word by word, requesting one
// bus slot per enabled channel (A,B,C, then D of the previous word) and driving the
// pointer/modulo address generator on each granted slot.
// Optional feature macro: BLT_NASTY_EN adds the nasty input, which suppresses the
// bus yield that otherwise follows every three consecutive granted slots.
module agnus_blitter_sequencer
  import agnus_blitter_pkg::*;
#(
  parameter int unsigned WBITS = 6,
  parameter int unsigned HBITS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk7_en,
  input  logic             start,
  input  logic [3:0]       use_abcd,
  input  logic             desc,
  input  logic [WBITS-1:0] bltwidth,
  input  logic [HBITS-1:0] bltheight,
  input  logic             bus_grant,
`ifdef BLT_NASTY_EN
  input  logic             nasty,
`endif
  output logic             bus_req,
  output logic [1:0]       ptrsel,
  output logic [1:0]       modsel,
  output logic             enaptr,
  output logic             incptr,
  output logic             decptr,
  output logic             addmod,
  output logic             submod,
  output logic [3:0]       chan_strobe,
  output logic             busy,
  output logic             done
);

  state_e     state;
  state_e     state_d;
  logic [3:0] use_q;
  logic       desc_q;
  logic       first;
  logic [3:0] served;
  logic       lastcol_d;
  logic [1:0] gcnt;

  logic [3:0] list;
  logic [3:0] pending;
  logic [1:0] chan;
  logic [3:0] stb;
  logic       lastcol;
  logic       lastword;
  logic       yield;
  logic       req;
  logic       fire;
  logic       word_end;
  logic       start_go;
  logic       lc;

  // Width/height counters
  agnus_blitter_sizecnt #(
    .WBITS (WBITS),
    .HBITS (HBITS)
  ) u_sizecnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (clk7_en),
    .load     (start_go),
    .step     (word_end),
    .width    (bltwidth),
    .height   (bltheight),
    .lastcol  (lastcol),
    .lastword (lastword)
  );

  // Slots still owed for the current word; D trails by one word so it is absent on the first
  always_comb begin
    list    = {use_q[3:1], use_q[0] & ~first};
    pending = '0;
    if (state == ST_SLOT) begin
      pending = list & ~served;
    end else if (state == ST_FLUSH_D) begin
      pending = STB_D;
    end
  end

  // Highest-priority pending channel, in A,B,C,D order
  always_comb begin
    chan = CHD;
    if (pending[3])      chan = CHA;
    else if (pending[2]) chan = CHB;
    else if (pending[1]) chan = CHC;
    stb = chan_onehot(chan);
  end

  // Give the bus back for one cycle after a burst of granted slots
`ifdef BLT_NASTY_EN
  assign yield = (gcnt == 2'(YIELD_AFTER)) && !nasty;
`else
  assign yield = (gcnt == 2'(YIELD_AFTER));
`endif

  // Slot handshake and word progress
  always_comb begin
    req      = (|pending) && !yield;
    fire     = req && bus_grant && clk7_en;
    start_go = (state == ST_IDLE) && start && clk7_en;
    word_end = (state == ST_SLOT) && clk7_en && !yield &&
               ((pending == '0) || (fire && ((pending & ~stb) == '0)));
    lc       = (chan == CHD) ? lastcol_d : lastcol;
  end

  // Address-generator controls are live only during a granted slot
  always_comb begin
    bus_req     = req;
    enaptr      = fire;
    ptrsel      = fire ? chan : 2'b00;
    modsel      = fire ? chan : 2'b00;
    incptr      = fire && !desc_q;
    decptr      = fire && desc_q;
    addmod      = fire && lc && !desc_q;
    submod      = fire && lc && desc_q;
    chan_strobe = fire ? stb : 4'b0000;
    busy        = (state != ST_IDLE);
    done        = (state == ST_DONE);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (start_go) state_d = ST_SLOT;
      end
      ST_SLOT: begin
        if (word_end && lastword) state_d = use_q[0] ? ST_FLUSH_D : ST_DONE;
      end
      ST_FLUSH_D: begin
        if (fire) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (clk7_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-blit configuration, per-word slot bookkeeping and the yield counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      use_q     <= '0;
      desc_q    <= 1'b0;
      first     <= 1'b0;
      served    <= '0;
      lastcol_d <= 1'b0;
      gcnt      <= '0;
    end else if (clk7_en) begin
      if (start_go) begin
        use_q     <= use_abcd;
        desc_q    <= desc;
        first     <= 1'b1;
        served    <= '0;
        lastcol_d <= 1'b0;
      end else if (word_end) begin
        served    <= '0;
        first     <= 1'b0;
        lastcol_d <= lastcol;
      end else if (fire) begin
        served    <= served | stb;
      end
      if (fire) begin
        gcnt <= (gcnt == 2'd3) ? 2'd3 : gcnt + 2'd1;
      end else begin
        gcnt <= 2'd0;
      end
    end
  end

endmodule
